// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer: parametrised VGA raster/sync generator with a
// NUM_SPRITES square-sprite compositor over a background colour.
// Sprite state is shadowed once per frame, so a frame never tears.
// Optional feature macro: VGA_GRID_OVERLAY_EN (all-ones grid lines every
// GRID_SIZE pixels, drawn above the background and below every sprite).

// Per-sprite hit test. Sums are 11 bits wide so that sprites near the right or
// bottom edge clip instead of wrapping around to column/row 0.
module vga_sprite_hit #(
  parameter int SPRITE_SIZE = 32
) (
  input  logic [9:0] h,
  input  logic [9:0] v,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       en,
  output logic       hit
);
  localparam logic [10:0] SZ = 11'(SPRITE_SIZE);

  logic [10:0] x_end, y_end;

  assign x_end = {1'b0, sx} + SZ;
  assign y_end = {1'b0, sy} + SZ;
  assign hit   = en && (h >= sx) && ({1'b0, h} < x_end)
                    && (v >= sy) && ({1'b0, v} < y_end);
endmodule

module vga_sprite_renderer #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 32,
  parameter int COLOR_W     = 3,
  parameter int GRID_SIZE   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [10*NUM_SPRITES-1:0]          sprite_x,
  input  logic [10*NUM_SPRITES-1:0]          sprite_y,
  input  logic [NUM_SPRITES-1:0]             sprite_en,
  input  logic [3*COLOR_W*NUM_SPRITES-1:0]   sprite_rgb,
  input  logic [3*COLOR_W-1:0]               bg_rgb,
  output logic [COLOR_W-1:0]                 red,
  output logic [COLOR_W-1:0]                 green,
  output logic [COLOR_W-1:0]                 blue,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               active,
  output logic [9:0]                         pixel_x,
  output logic [9:0]                         pixel_y,
  output logic                               frame_start
);
  localparam int RGB_W = 3 * COLOR_W;

  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] H_SS   = 10'(H_DISPLAY + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_DISPLAY + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] V_SS   = 10'(V_DISPLAY + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_DISPLAY + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);

  logic [9:0] h, v;
  logic       frame_end;
  logic       started;

  // shadow copies of the sprite inputs, one lane per sprite
  logic [NUM_SPRITES-1:0][9:0]       sx_q, sy_q;
  logic [NUM_SPRITES-1:0]            en_q;
  logic [NUM_SPRITES-1:0][RGB_W-1:0] rgb_q;
  logic [NUM_SPRITES-1:0]            hit;

  logic             vis, hs_act, vs_act;
  logic [RGB_W-1:0] rgb_d;

  assign frame_end = (h == H_LAST) && (v == V_LAST);
  assign vis       = (h < H_VIS) && (v < V_VIS);
  assign hs_act    = (h >= H_SS) && (h < H_SE);
  assign vs_act    = (v >= V_SS) && (v < V_SE);

  // raster counters: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

  // latch sprite state at the last pixel of each frame; started gates the
  // very first frame_start so it is not raised on the post-reset frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      en_q    <= '0;
      rgb_q   <= '0;
      started <= 1'b0;
    end else if (frame_end) begin
      sx_q    <= sprite_x;
      sy_q    <= sprite_y;
      en_q    <= sprite_en;
      rgb_q   <= sprite_rgb;
      started <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_lane
    vga_sprite_hit #(.SPRITE_SIZE(SPRITE_SIZE)) u_hit (
      .h   (h),
      .v   (v),
      .sx  (sx_q[i]),
      .sy  (sy_q[i]),
      .en  (en_q[i]),
      .hit (hit[i])
    );
  end

`ifdef VGA_GRID_OVERLAY_EN
  localparam logic [9:0] G_MASK = 10'(GRID_SIZE - 1);
  logic on_grid;
  assign on_grid = ((h & G_MASK) == '0) || ((v & G_MASK) == '0);
`endif

  // compositor: blank -> 0, else bg, grid, then lowest-index sprite on top
  always_comb begin
    rgb_d = '0;
    if (vis) begin
      rgb_d = bg_rgb;
`ifdef VGA_GRID_OVERLAY_EN
      if (on_grid) rgb_d = '1;
`endif
      for (int i = NUM_SPRITES - 1; i >= 0; i--)
        if (hit[i]) rgb_d = rgb_q[i];
    end
  end

  // single output stage: every output reflects the previous counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red, green, blue} <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      active      <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      {red, green, blue} <= rgb_d;
      hsync       <= hs_act ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_act ? SYNC_POL : ~SYNC_POL;
      active      <= vis;
      pixel_x     <= h;
      pixel_y     <= v;
      frame_start <= started && (h == '0) && (v == '0);
    end
  end
endmodule
